// File: rtl/dma_burst_reader.sv
// Issues back-to-back fixed-length AXI4 INCR read bursts and streams every
// accepted read beat straight into the ring buffer's write port.
module dma_burst_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int BURST_LENGTH = 128,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_bursts,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic                  buf_wen,
    output logic [DATA_WIDTH-1:0] buf_din,
    input  logic                  buf_full
);
    localparam int BYTES = BURST_LENGTH * DATA_WIDTH / 8;
    localparam int BEAT_W = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LENGTH - 1);
    localparam logic [ADDR_WIDTH-1:0] BYTES_A = ADDR_WIDTH'(BYTES);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;

    state_t                 state, state_nxt;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [CNT_WIDTH-1:0]   remaining;
    logic [BEAT_W-1:0]      beat;
    logic                   err_q;
    logic                   misaligned, zero_job, beat_acc, is_last, burst_end, beat_bad;

    assign misaligned = (base_addr % BYTES_A) != '0;
    assign zero_job   = (num_bursts == '0);
    assign is_last    = (beat == LAST_BEAT);
    assign beat_acc   = m_rvalid && m_rready;
    assign burst_end  = beat_acc && is_last;
    // Burst length is enforced by our own counter; rlast only serves as a consistency check.
    assign beat_bad   = (m_rresp != 2'b00) || (m_rlast != is_last);

    assign m_arlen   = 8'(BURST_LENGTH - 1);
    assign m_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_arburst = 2'b01;
    assign m_araddr  = addr;
    assign err       = err_q;
    // Combinational so a rising full flag blocks the beat in the same cycle.
    assign m_rready  = (state == DATA) && !buf_full;
    assign buf_wen   = beat_acc;
    assign buf_din   = m_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        m_arvalid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (zero_job || misaligned) ? FIN : ADDR;
            end
            ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) state_nxt = DATA;
            end
            DATA: begin
                if (burst_end) state_nxt = (remaining == CNT_WIDTH'(1)) ? FIN : ADDR;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            beat      <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    addr      <= base_addr;
                    remaining <= num_bursts;
                    err_q     <= misaligned;
                end
                ADDR: if (m_arready) beat <= '0;
                DATA: if (beat_acc) begin
                    beat <= beat + BEAT_W'(1);
                    if (beat_bad) err_q <= 1'b1;
                    if (is_last) begin
                        remaining <= remaining - CNT_WIDTH'(1);
                        addr      <= addr + BYTES_A;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_burst_reader.sv
// Randomised bench: a slave model feeds beats, a scoreboard predicts AR addresses,
// buffer writes and job completion from the job description alone.
module tb_dma_burst_reader;
    localparam int DW = 32, AW = 32, BL = 4, CW = 16, BYTES = BL * DW / 8;

    logic          clk = 0, rst_n = 0, start = 0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] num_bursts = '0;
    logic          busy, done, err, m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic          buf_wen, buf_full;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst, m_rresp;
    logic [DW-1:0] m_rdata, buf_din;

    dma_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LENGTH(BL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_bursts(num_bursts),
        .busy(busy), .done(done), .err(err), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .buf_wen(buf_wen), .buf_din(buf_din), .buf_full(buf_full));

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] data; logic [1:0] resp; logic last; } beat_t;
    typedef struct { logic err; int cyc; } done_t;   // cyc < 0: one cycle after final write

    beat_t         slv_q[$];
    logic [AW-1:0] exp_ar_q[$];
    logic [DW-1:0] exp_wr_q[$];
    done_t         exp_done_q[$];
    int cyc = 0, total = 0, passed = 0, granted = 0;
    int wr_count = 0, done_count = 0, last_wr_cyc = 0;
    bit eager = 0, full_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endfunction

    // AXI slave model: one AR grants BL beats, beats are served from slv_q in order.
    initial begin
        bit ar_hs, r_hs;
        m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = '0; m_rlast = 0; buf_full = 0;
        forever begin
            @(negedge clk);
            ar_hs = rst_n && m_arvalid && m_arready;
            r_hs  = rst_n && m_rvalid && m_rready;
            @(posedge clk); #1;
            if (!rst_n) begin
                granted = 0; m_rvalid = 0; m_arready = 0; buf_full = 0;
            end else begin
                if (ar_hs) granted += BL;
                if (r_hs) begin void'(slv_q.pop_front()); granted--; end
                m_arready = eager || ($urandom_range(3) != 0);
                buf_full  = full_en && ($urandom_range(2) == 0);
                m_rvalid  = (granted > 0) && (slv_q.size() > 0) && (eager || $urandom_range(4) != 0);
                if (slv_q.size() > 0) begin
                    m_rdata = slv_q[0].data; m_rresp = slv_q[0].resp; m_rlast = slv_q[0].last;
                end
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit prev_done;
        done_t d;
        prev_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) prev_done = 0;
            else begin
                if (prev_done) chk("busy_after_done", busy, 0);
                if (buf_full) chk("rready_while_full", m_rready, 0);
                if (m_arvalid && m_arready) begin
                    if (exp_ar_q.size() == 0) chk("unexpected_ar", m_araddr, 64'hDEAD);
                    else chk("ar_addr", m_araddr, exp_ar_q.pop_front());
                    chk("ar_const", {m_arlen, m_arsize, m_arburst}, {8'd3, 3'd2, 2'b01});
                end
                if (buf_wen) begin
                    wr_count++;
                    last_wr_cyc = cyc;
                    if (exp_wr_q.size() == 0) chk("unexpected_write", buf_din, 64'hDEAD);
                    else chk("wr_data", buf_din, exp_wr_q.pop_front());
                end
                if (done) begin
                    done_count++;
                    if (exp_done_q.size() == 0) chk("unexpected_done", done, 0);
                    else begin
                        d = exp_done_q.pop_front();
                        chk("done_err", err, d.err);
                        chk("done_cycle", cyc, (d.cyc < 0) ? last_wr_cyc + 1 : d.cyc);
                        chk("writes_drained", exp_wr_q.size(), 0);
                        chk("ar_drained", exp_ar_q.size(), 0);
                    end
                end
                prev_done = done;
            end
        end
    end

    // Reference model: job description -> expected ARs, beats, writes, error.
    task automatic launch(input logic [AW-1:0] base, input int n, input int bad_resp,
                          input int early_last, input bit drop_last);
        bit mis = (base % BYTES) != 0;
        bit e = mis;
        if (!mis) begin
            for (int b = 0; b < n; b++) begin
                exp_ar_q.push_back(base + AW'(b * BYTES));
                for (int k = 0; k < BL; k++) begin
                    beat_t bt;
                    bt.data = $urandom; bt.resp = 2'b00; bt.last = (k == BL - 1);
                    if (b == 0 && k == bad_resp) begin bt.resp = 2'b10; e = 1; end
                    if (b == 0 && k == early_last && k != BL - 1) begin bt.last = 1; e = 1; end
                    if (b == n - 1 && drop_last && k == BL - 1) begin bt.last = 0; e = 1; end
                    slv_q.push_back(bt);
                    exp_wr_q.push_back(bt.data);
                end
            end
        end
        @(posedge clk); #1;
        start = 1; base_addr = base; num_bursts = CW'(n);
        exp_done_q.push_back('{e, (mis || n == 0) ? cyc + 1 : -1});
        @(posedge clk); #1;
        start = 0; base_addr = $urandom; num_bursts = CW'($urandom);
    endtask

    task automatic wait_done(input int d0);
        int k = 0;
        while (done_count == d0 && k < 3000) begin @(posedge clk); k++; end
        if (done_count == d0) chk("job_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic run_job(input logic [AW-1:0] base, input int n, input int bad_resp,
                           input int early_last, input bit drop_last, input bit poke);
        int d0 = done_count;
        launch(base, n, bad_resp, early_last, drop_last);
        if (poke) begin
            // A start while busy must be ignored entirely.
            repeat (2) @(posedge clk);
            #1 start = 1; base_addr = 32'h0008_0000; num_bursts = 5;
            @(posedge clk); #1 start = 0;
        end
        wait_done(d0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_arvalid"}, m_arvalid, 0);
        chk({tag, "_rready"}, m_rready, 0);
        chk({tag, "_wen"}, buf_wen, 0);
        chk({tag, "_araddr"}, m_araddr, 0);
        chk({tag, "_ar_const"}, {m_arlen, m_arsize, m_arburst}, {8'd3, 3'd2, 2'b01});
    endtask

    initial begin
        #1 check_reset_values("rst");
        @(posedge clk); #3 rst_n = 1;

        eager = 1;
        run_job(32'h1000, 2, -1, -1, 0, 0);
        eager = 0; full_en = 1;
        run_job(32'h1000, 2, -1, -1, 0, 0);
        full_en = 0;
        run_job(32'h2000, 0, -1, -1, 0, 0);           // zero bursts
        run_job(32'h1004, 3, -1, -1, 0, 0);           // misaligned
        run_job(32'h3000, 1, -1, -1, 0, 0);           // err cleared by next start
        run_job(32'h4000, 1, 2, 1, 0, 0);             // bad resp on beat 3, rlast on beat 2
        run_job(32'h5000, 2, -1, -1, 1, 0);           // missing rlast on final beat
        run_job(32'hFFFF_FFF0, 2, -1, -1, 0, 0);      // address wrap
        run_job(32'h6000, 2, -1, -1, 0, 1);           // start while busy

        // Reset mid-burst
        begin
            int w0 = wr_count, k = 0;
            launch(32'h7000, 2, -1, -1, 0);
            while (wr_count < w0 + 2 && k < 1000) begin @(posedge clk); k++; end
            if (wr_count < w0 + 2) chk("midburst_timeout", 0, 1);
            @(posedge clk); #2 rst_n = 0;
            #1 check_reset_values("midrst");
            slv_q.delete(); exp_ar_q.delete(); exp_wr_q.delete(); exp_done_q.delete();
            @(posedge clk); #3 rst_n = 1;
        end
        run_job(32'h8000, 2, -1, -1, 0, 0);

        for (int j = 0; j < 20; j++) begin
            logic [AW-1:0] b = $urandom & ~32'(BYTES - 1);
            int n = $urandom_range(0, 4);
            full_en = $urandom_range(1);
            if ($urandom_range(7) == 0) begin b = b | AW'($urandom_range(1, BYTES - 1)); n = n + 1; end
            run_job(b, n, ($urandom_range(5) == 0) ? $urandom_range(0, BL - 1) : -1,
                    ($urandom_range(5) == 0) ? $urandom_range(0, BL - 2) : -1,
                    $urandom_range(7) == 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks passed", passed, total);
        $fatal(1);
    end
endmodule
